// File: rtl/code_loader_pkg.sv
// Shared types and defaults for the program-load controller.
package code_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_RUN,
    S_ERROR
  } state_t;

  localparam int unsigned MAX_WORDS_DEF = 512;

  // A word count is legal when it is non-zero and fits in code memory.
  function automatic logic len_legal(input logic [15:0] len, input int unsigned max_words);
    return (len != 16'd0) && ({16'd0, len} <= max_words);
  endfunction

endpackage

// File: rtl/code_loader.sv
// Boot loader: receives a length-prefixed big-endian word stream, writes it to
// code memory from address 0, then releases the processor via run.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr,
  output logic [DATA_W-1:0] code_data,
  output logic              run,
  output logic              busy,
  output logic              err
);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] len_next;
  logic [15:0] addr_ext;
  logic        accept;

  assign len_next = {cnt[15:8], in_data};
  assign addr_ext = 16'(code_addr);

  // reload masks in_ready so a byte offered alongside it is never consumed.
  assign in_ready = !reload && (state == S_LEN_HI || state == S_LEN_LO ||
                                state == S_DATA_HI || state == S_DATA_LO);
  assign busy     = (state != S_RUN) && (state != S_ERROR);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_LEN_HI;
      cnt       <= '0;
      code_w_en <= 1'b0;
      code_addr <= '0;
      code_data <= '0;
      run       <= 1'b0;
      err       <= 1'b0;
    end else begin
      code_w_en <= 1'b0;
      if (reload) begin
        state     <= S_LEN_HI;
        code_addr <= '0;
        run       <= 1'b0;
        err       <= 1'b0;
      end else begin
        case (state)
          S_LEN_HI: if (accept) begin
            cnt[15:8] <= in_data;
            state     <= S_LEN_LO;
          end
          S_LEN_LO: if (accept) begin
            cnt[7:0] <= in_data;
            if (len_legal(len_next, MAX_WORDS)) begin
              code_addr <= '0;
              state     <= S_DATA_HI;
            end else begin
              err   <= 1'b1;
              state <= S_ERROR;
            end
          end
          S_DATA_HI: if (accept) begin
            code_data[DATA_W-1 -: 8] <= in_data;
            state                    <= S_DATA_LO;
          end
          S_DATA_LO: if (accept) begin
            code_data[7:0] <= in_data;
            code_w_en      <= 1'b1;
            state          <= S_WRITE;
          end
          S_WRITE: begin
            // Terminal compare happens before increment so the address never wraps.
            if (addr_ext == cnt - 16'd1) begin
              run   <= 1'b1;
              state <= S_RUN;
            end else begin
              code_addr <= code_addr + 1'b1;
              state     <= S_DATA_HI;
            end
          end
          S_RUN:   state <= S_RUN;
          S_ERROR: state <= S_ERROR;
          default: state <= S_LEN_HI;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Randomized self-checking bench for code_loader against a stream-level model.
module tb_code_loader;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MAX_WORDS = 512;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              code_w_en;
  logic [ADDR_W-1:0] code_addr;
  logic [DATA_W-1:0] code_data;
  logic              run;
  logic              busy;
  logic              err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  code_loader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .reload   (reload),
    .code_w_en(code_w_en),
    .code_addr(code_addr),
    .code_data(code_data),
    .run      (run),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives a whole stream with random valid gaps and checks every cycle
  // against what the stream itself implies (writes, run, err, handshake).
  task automatic run_stream(input logic [7:0] q[$], input int unsigned max_gap);
    logic [15:0] len;
    bit          legal, acc, exp_wen, exp_run, exp_err, last_wen, last_final, done;
    int unsigned n_exp, idx, cur, gap, cyc, tail, writes, budget;
    len        = {q[0], q[1]};
    legal      = (len != 16'd0) && (int'(len) <= MAX_WORDS);
    n_exp      = legal ? 2 + 2 * int'(len) : 2;
    budget     = n_exp * (max_gap + 3) + 50;
    idx = 0; cur = 0; gap = 0; cyc = 0; tail = 0; writes = 0;
    exp_run = 0; exp_err = 0; last_wen = 0; last_final = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (idx < q.size() && gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        in_data  = (idx < q.size()) ? q[idx] : 8'($urandom);
      end
      #1;
      check("in_ready", in_ready, !(exp_run || exp_err || last_wen));
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        cur = idx;
        idx++;
        gap = $urandom_range(max_gap, 0);
      end
      exp_wen = acc && legal && cur >= 3 && (cur % 2 == 1);
      exp_run = exp_run || last_final;
      if (acc && cur == 1 && !legal) exp_err = 1'b1;
      check("code_w_en", code_w_en, exp_wen);
      if (exp_wen) begin
        check("code_addr", code_addr, (cur - 3) / 2);
        check("code_data", code_data, {q[cur-1], q[cur]});
        writes++;
      end
      check("run", run, exp_run);
      check("err", err, exp_err);
      check("busy", busy, !(exp_run || exp_err));
      last_final = exp_wen && ((cur - 3) / 2 == int'(len) - 1);
      last_wen   = exp_wen;
      if (exp_run || exp_err) tail++;
      if (tail >= 4) done = 1'b1;
      cyc++;
      if (!done && cyc > budget) begin
        check("timeout", cyc, budget);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("n_writes", writes, legal ? int'(len) : 0);
  endtask

  task automatic pulse_reload(input bit with_byte);
    @(negedge clk);
    reload   = 1'b1;
    in_valid = with_byte;
    in_data  = 8'h5A;
    #1;
    check("ready_in_reload", in_ready, 0);
    @(posedge clk);
    #1;
    check("reload_run", run, 0);
    check("reload_err", err, 0);
    check("reload_addr", code_addr, 0);
    check("reload_busy", busy, 1);
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    #1;
    check("ready_after_reload", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("send_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_w_en"}, code_w_en, 0);
    check({tag, "_addr"}, code_addr, 0);
    check({tag, "_data"}, code_data, 0);
    check({tag, "_run"}, run, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic random_load(output logic [7:0] q[$]);
    logic [15:0] len;
    q = {};
    case ($urandom_range(5, 0))
      0:       len = 16'($urandom_range(65535, MAX_WORDS + 1));
      1:       len = 16'd0;
      default: len = 16'($urandom_range(8, 1));
    endcase
    q.push_back(len[15:8]);
    q.push_back(len[7:0]);
    if (len != 0 && int'(len) <= MAX_WORDS)
      for (int unsigned i = 0; i < 2 * int'(len); i++) q.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0] q[$];
    rst_n    = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    q = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    run_stream(q, 0);
    pulse_reload(1'b1);
    q = {8'h00, 8'h01, 8'hBE, 8'hEF};
    run_stream(q, 0);

    pulse_reload(1'b0);
    q = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    run_stream(q, 3);

    pulse_reload(1'b0);
    q = {8'h00, 8'h00};
    run_stream(q, 0);
    pulse_reload(1'b0);
    q = {8'h02, 8'h01};
    run_stream(q, 2);
    pulse_reload(1'b0);

    q = {8'h02, 8'h00};
    for (int unsigned i = 0; i < 2 * MAX_WORDS; i++) q.push_back(8'($urandom));
    run_stream(q, 0);

    for (int unsigned n = 0; n < 8; n++) begin
      pulse_reload(n[0]);
      random_load(q);
      run_stream(q, $urandom_range(3, 0));
    end

    // Reset in the middle of word 1 of a 3-word load.
    pulse_reload(1'b0);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    q = {8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_stream(q, 1);

    // Reload partway through a load discards the partial word.
    pulse_reload(1'b0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hAA);
    pulse_reload(1'b1);
    q = {8'h00, 8'h02, 8'hC0, 8'hDE, 8'hF0, 8'h0D};
    run_stream(q, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
